// File: rtl/fht_seq_pkg.sv
// rtl/fht_seq_pkg.sv - FSM state, width constants and butterfly index arithmetic for the FHT sequencer
package fht_pkg;

   localparam int MAX_LOG_N = 12;
   localparam int SW        = $clog2(MAX_LOG_N);
   localparam int CW        = MAX_LOG_N - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [MAX_LOG_N-1:0] idx0;
      logic [MAX_LOG_N-1:0] idx1;
      logic [MAX_LOG_N-1:0] idx2;
      logic [CW-1:0]        tw;
   } idx_t;

   // g*B is c with its low s bits cleared and shifted up one, so no multiplier is needed.
   function automatic idx_t fht_idx(input int log_n, input logic [SW-1:0] s, input logic [CW-1:0] c);
      logic [MAX_LOG_N-1:0] one;
      logic [MAX_LOG_N-1:0] h;
      logic [MAX_LOG_N-1:0] mask;
      logic [MAX_LOG_N-1:0] ce;
      logic [MAX_LOG_N-1:0] k;
      logic [MAX_LOG_N-1:0] gb;
      idx_t                 r;
      one    = MAX_LOG_N'(1);
      h      = one << s;
      mask   = h - one;
      ce     = {1'b0, c};
      k      = ce & mask;
      gb     = (ce & ~mask) << 1;
      r.idx0 = gb | k;
      r.idx1 = gb | h | k;
      r.idx2 = gb | h | ((h - k) & mask);
      r.tw   = CW'(k << (log_n - 1 - int'(s)));
      return r;
   endfunction

endpackage

// File: rtl/fht_seq_if.sv
// rtl/fht_seq_if.sv - control, read-address and write-back bundle of the FHT operand sequencer
interface fht_seq_if #(parameter int LOG_N = 4);

   logic             iSTART;
   logic             oBUSY;
   logic             oDONE;
   logic             oRD_EN;
   logic [LOG_N-1:0] oADDR_X1;
   logic [LOG_N-1:0] oADDR_X2;
   logic             oRD_EN_X0;
   logic [LOG_N-1:0] oADDR_X0;
   logic [LOG_N-2:0] oADDR_TW;
   logic             oRD_BANK;
   logic             oWR_EN;
   logic [LOG_N-1:0] oADDR_Y0;
   logic [LOG_N-1:0] oADDR_Y1;

   modport master (
      input  iSTART,
      output oBUSY, oDONE, oRD_EN, oADDR_X1, oADDR_X2, oRD_EN_X0, oADDR_X0,
             oADDR_TW, oRD_BANK, oWR_EN, oADDR_Y0, oADDR_Y1
   );

   modport slave (
      output iSTART,
      input  oBUSY, oDONE, oRD_EN, oADDR_X1, oADDR_X2, oRD_EN_X0, oADDR_X0,
             oADDR_TW, oRD_BANK, oWR_EN, oADDR_Y0, oADDR_Y1
   );

endinterface

// File: rtl/fht_seq_dly.sv
// rtl/fht_seq_dly.sv - fixed-depth shift register with asynchronous clear
module fht_dly #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_wire
         assign q = d;
      end else begin : g_sr
         logic [WIDTH-1:0] sr [DEPTH];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
            end else begin
               sr[0] <= d;
               for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
         end

         assign q = sr[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/fht_seq.sv
// rtl/fht_seq.sv - stage/butterfly sequencer issuing FHT operand reads and delayed write-backs
module fht_seq
   import fht_pkg::*;
#(
   parameter int LOG_N    = 4,
   parameter int PIPE_LAT = 3,
   parameter int X0_SKEW  = 1
) (
   input  logic       iCLK,
   input  logic       iRESET,
   fht_seq_if.master  bus
);

   localparam int STW = $clog2(LOG_N);
   localparam int DW  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   localparam logic [LOG_N-2:0] C_LAST = '1;
   localparam logic [LOG_N-2:0] C_ONE  = (LOG_N-1)'(1);
   localparam logic [STW-1:0]   S_LAST = STW'(LOG_N - 1);
   localparam logic [STW-1:0]   S_ONE  = STW'(1);
   localparam logic [DW-1:0]    D_LAST = DW'(PIPE_LAT - 1);
   localparam logic [DW-1:0]    D_ONE  = DW'(1);

   state_t           state;
   logic [STW-1:0]   stage;
   logic [LOG_N-2:0] cnt;
   logic [DW-1:0]    dcnt;
   logic             busy;
   logic             done;
   logic             rd_en;
   logic             rd_bank;
   logic [LOG_N-1:0] a0;
   logic [LOG_N-1:0] a1;
   logic [LOG_N-1:0] a2;
   logic [LOG_N-2:0] atw;

   logic [STW-1:0]   nxt_s;
   logic [LOG_N-2:0] nxt_c;
   logic             issue;
   idx_t             nxt;
   logic             unused_nxt;

   // Indices of the butterfly that would be issued at the coming edge.
   always_comb begin
      nxt_s = '0;
      nxt_c = '0;
      issue = 1'b0;
      case (state)
         S_IDLE:  issue = bus.iSTART;
         S_RUN: begin
            nxt_s = stage;
            nxt_c = cnt + C_ONE;
            issue = (cnt != C_LAST);
         end
         S_DRAIN: begin
            nxt_s = stage + S_ONE;
            issue = (dcnt == D_LAST) && (stage != S_LAST);
         end
         default: issue = 1'b0;
      endcase
      nxt = fht_idx(LOG_N, SW'(nxt_s), CW'(nxt_c));
   end

   assign unused_nxt = ^nxt;

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         state   <= S_IDLE;
         stage   <= '0;
         cnt     <= '0;
         dcnt    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         rd_en   <= 1'b0;
         rd_bank <= 1'b0;
         a0      <= '0;
         a1      <= '0;
         a2      <= '0;
         atw     <= '0;
      end else begin
         done  <= 1'b0;
         rd_en <= issue;
         if (issue) begin
            a0  <= nxt.idx0[LOG_N-1:0];
            a1  <= nxt.idx1[LOG_N-1:0];
            a2  <= nxt.idx2[LOG_N-1:0];
            atw <= nxt.tw[LOG_N-2:0];
         end
         case (state)
            S_IDLE: begin
               if (bus.iSTART) begin
                  state   <= S_RUN;
                  stage   <= '0;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  rd_bank <= 1'b0;
               end
            end
            S_RUN: begin
               if (cnt == C_LAST) begin
                  state <= S_DRAIN;
                  dcnt  <= '0;
               end else begin
                  cnt <= nxt_c;
               end
            end
            // Next stage reads what this one writes, so wait for the pipeline to empty.
            S_DRAIN: begin
               if (dcnt == D_LAST) begin
                  if (stage == S_LAST) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state   <= S_RUN;
                     stage   <= nxt_s;
                     cnt     <= '0;
                     rd_bank <= ~rd_bank;
                  end
               end else begin
                  dcnt <= dcnt + D_ONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   logic [LOG_N:0]   x0_q;
   logic [2*LOG_N:0] wb_q;

   fht_dly #(.DEPTH(X0_SKEW), .WIDTH(LOG_N + 1)) u_x0_dly (
      .clk (iCLK),
      .rst (iRESET),
      .d   ({rd_en, a0}),
      .q   (x0_q)
   );

   fht_dly #(.DEPTH(PIPE_LAT), .WIDTH(2*LOG_N + 1)) u_wb_dly (
      .clk (iCLK),
      .rst (iRESET),
      .d   ({rd_en, a0, a1}),
      .q   (wb_q)
   );

   assign bus.oBUSY     = busy;
   assign bus.oDONE     = done;
   assign bus.oRD_EN    = rd_en;
   assign bus.oADDR_X1  = a1;
   assign bus.oADDR_X2  = a2;
   assign bus.oADDR_TW  = atw;
   assign bus.oRD_BANK  = rd_bank;
   assign bus.oRD_EN_X0 = x0_q[LOG_N];
   assign bus.oADDR_X0  = x0_q[LOG_N-1:0];
   assign bus.oWR_EN    = wb_q[2*LOG_N];
   assign bus.oADDR_Y0  = wb_q[2*LOG_N-1:LOG_N];
   assign bus.oADDR_Y1  = wb_q[LOG_N-1:0];

endmodule

// File: tb/tb_fht_seq.sv
// tb/tb_fht_seq.sv - scoreboard bench for fht_seq with an integrated real-valued DHT datapath
module tb_fht_seq;

   localparam int  LOG_N = 4;
   localparam int  N     = 16;
   localparam int  NH    = 8;
   localparam real PI    = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fht_seq_if #(.LOG_N(LOG_N)) if0 ();
   fht_seq_if #(.LOG_N(LOG_N)) if1 ();

   fht_seq #(.LOG_N(LOG_N), .PIPE_LAT(3), .X0_SKEW(1)) u0 (.iCLK(clk), .iRESET(rst), .bus(if0));
   fht_seq #(.LOG_N(LOG_N), .PIPE_LAT(5), .X0_SKEW(1)) u1 (.iCLK(clk), .iRESET(rst), .bus(if1));

   bit sel = 1'b0;
   logic             m_busy, m_done, m_rd_en, m_rd_en_x0, m_rd_bank, m_wr_en;
   logic [LOG_N-1:0] m_x0, m_x1, m_x2, m_y0, m_y1;
   logic [LOG_N-2:0] m_tw;

   always_comb begin
      if (sel) begin
         m_busy = if1.oBUSY;   m_done = if1.oDONE;   m_rd_en = if1.oRD_EN;
         m_rd_en_x0 = if1.oRD_EN_X0; m_rd_bank = if1.oRD_BANK; m_wr_en = if1.oWR_EN;
         m_x0 = if1.oADDR_X0;  m_x1 = if1.oADDR_X1;  m_x2 = if1.oADDR_X2;
         m_y0 = if1.oADDR_Y0;  m_y1 = if1.oADDR_Y1;  m_tw = if1.oADDR_TW;
      end else begin
         m_busy = if0.oBUSY;   m_done = if0.oDONE;   m_rd_en = if0.oRD_EN;
         m_rd_en_x0 = if0.oRD_EN_X0; m_rd_bank = if0.oRD_BANK; m_wr_en = if0.oWR_EN;
         m_x0 = if0.oADDR_X0;  m_x1 = if0.oADDR_X1;  m_x2 = if0.oADDR_X2;
         m_y0 = if0.oADDR_Y0;  m_y1 = if0.oADDR_Y1;  m_tw = if0.oADDR_TW;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mon_outs();
      return {3'b0, m_busy, m_done, m_rd_en, m_rd_en_x0, m_rd_bank, m_wr_en,
              m_x0, m_x1, m_x2, m_tw, m_y0, m_y1};
   endfunction

   typedef struct {
      int cyc;
      int i0;
      int i1;
      int i2;
      int tw;
      int bank;
   } ent_t;

   ent_t erd[$];
   ent_t ex0[$];
   ent_t ewr[$];
   real  ram [2][N];
   real  xin [N];
   real  qx1[$];
   real  qx2[$];
   real  qy0[$];
   real  qy1[$];
   int   qtw[$];

   function automatic int bitrev(input int v);
      int r = 0;
      for (int b = 0; b < LOG_N; b++)
         if ((v & (1 << b)) != 0) r |= 1 << (LOG_N - 1 - b);
      return r;
   endfunction

   // One full transform: expected reads/x0/writes queued up front, popped as cycles pass.
   task automatic run(input bit which, input int lat, input int done_cyc, input int inj_a, input int inj_b);
      int   t_per;
      int   rd_cnt;
      int   wr_cnt;
      int   bank;
      ent_t e;
      real  x0v, x1v, x2v, tv, ang, refv, err;
      t_per  = NH + lat;
      rd_cnt = 0;
      wr_cnt = 0;
      sel    = which;
      erd.delete(); ex0.delete(); ewr.delete();
      qx1.delete(); qx2.delete(); qy0.delete(); qy1.delete(); qtw.delete();
      for (int n = 0; n < N; n++) begin
         xin[n] = real'(int'($urandom_range(2000)) - 1000);
         ram[0][bitrev(n)] = xin[n];
         ram[1][n] = 0.0;
      end
      for (int s = 0; s < LOG_N; s++) begin
         for (int c = 0; c < NH; c++) begin
            int h, g, k;
            h      = 2 ** s;
            g      = c / h;
            k      = c % h;
            e.i0   = g * 2 * h + k;
            e.i1   = e.i0 + h;
            e.i2   = g * 2 * h + h + ((h - k) % h);
            e.tw   = k * (N / (2 * h));
            e.bank = s % 2;
            e.cyc  = s * t_per + 1 + c;
            erd.push_back(e);
            e.cyc  = s * t_per + 2 + c;
            ex0.push_back(e);
            e.cyc  = s * t_per + 1 + c + lat;
            ewr.push_back(e);
         end
      end

      @(negedge clk);
      if (which) if1.iSTART = 1'b1; else if0.iSTART = 1'b1;
      @(posedge clk);
      for (int t = 1; t <= done_cyc + 4; t++) begin
         @(negedge clk);
         if0.iSTART = 1'b0;
         if1.iSTART = 1'b0;
         chk("busy", m_busy, t < done_cyc);
         chk("done", m_done, t == done_cyc);

         if (erd.size() > 0 && erd[0].cyc == t) begin
            e = erd.pop_front();
            chk("rd_en", m_rd_en, 1);
            chk("addr_x1", m_x1, e.i1);
            chk("addr_x2", m_x2, e.i2);
            chk("addr_tw", m_tw, e.tw);
            chk("rd_bank", m_rd_bank, e.bank);
         end else begin
            chk("rd_en_idle", m_rd_en, 0);
         end

         if (ex0.size() > 0 && ex0[0].cyc == t) begin
            e = ex0.pop_front();
            chk("rd_en_x0", m_rd_en_x0, 1);
            chk("addr_x0", m_x0, e.i0);
         end else begin
            chk("rd_en_x0_idle", m_rd_en_x0, 0);
         end

         if (ewr.size() > 0 && ewr[0].cyc == t) begin
            e = ewr.pop_front();
            chk("wr_en", m_wr_en, 1);
            chk("addr_y0", m_y0, e.i0);
            chk("addr_y1", m_y1, e.i1);
            chk("wr_bank_not_read", m_rd_bank, e.bank);
         end else begin
            chk("wr_en_idle", m_wr_en, 0);
         end

         // Datapath: RAM read, butterfly, write-back into the bank not being read.
         if (m_rd_en) begin
            rd_cnt++;
            bank = int'(m_rd_bank);
            qx1.push_back(ram[bank][m_x1]);
            qx2.push_back(ram[bank][m_x2]);
            qtw.push_back(int'(m_tw));
         end
         if (m_rd_en_x0 && qx1.size() > 0) begin
            x0v = ram[int'(m_rd_bank)][m_x0];
            x1v = qx1.pop_front();
            x2v = qx2.pop_front();
            ang = 2.0 * PI * real'(qtw.pop_front()) / real'(N);
            tv  = x1v * $cos(ang) + x2v * $sin(ang);
            qy0.push_back(x0v + tv);
            qy1.push_back(x0v - tv);
         end
         if (m_wr_en) begin
            wr_cnt++;
            if (qy0.size() > 0) begin
               bank = 1 - int'(m_rd_bank);
               ram[bank][m_y0] = qy0.pop_front();
               ram[bank][m_y1] = qy1.pop_front();
            end
         end

         if (t == inj_a || t == inj_b) begin
            if (which) if1.iSTART = 1'b1; else if0.iSTART = 1'b1;
         end
      end
      if0.iSTART = 1'b0;
      if1.iSTART = 1'b0;

      chk("rd_count", rd_cnt, 32);
      chk("wr_count", wr_cnt, 32);
      chk("sb_empty", erd.size() + ex0.size() + ewr.size(), 0);
      for (int k = 0; k < N; k++) begin
         refv = 0.0;
         for (int n = 0; n < N; n++) begin
            ang  = 2.0 * PI * real'(n * k) / real'(N);
            refv = refv + xin[n] * ($cos(ang) + $sin(ang));
         end
         err = ram[LOG_N % 2][k] - refv;
         chk("dht_bin", (err < 4.0) && (err > -4.0), 1);
      end
   endtask

   initial begin
      if0.iSTART = 1'b0;
      if1.iSTART = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      sel = 1'b0;
      #1 chk("reset_outs_u0", mon_outs(), 0);
      sel = 1'b1;
      #1 chk("reset_outs_u1", mon_outs(), 0);
      @(negedge clk);
      rst = 1'b0;

      run(1'b0, 3, 45, 5, 45);
      run(1'b0, 3, 45, 0, 0);

      sel = 1'b0;
      @(negedge clk);
      if0.iSTART = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if0.iSTART = 1'b0;
      repeat (12) @(posedge clk);
      #2 chk("pre_reset_rd_en", m_rd_en, 1);
      #1 rst = 1'b1;
      #1 chk("async_reset_outs", mon_outs(), 0);
      repeat (2) @(negedge clk);
      chk("held_reset_outs", mon_outs(), 0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("post_reset_quiet", {m_busy, m_rd_en, m_wr_en, m_rd_en_x0}, 0);
      end

      run(1'b0, 3, 45, 0, 0);
      run(1'b1, 5, 53, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fht_seq.md
# fht_seq

Operand sequencer for the in-place radix-2 FHT: drives the read side of the ping-pong data RAM and the twiddle ROM that feed `fht_but`, and generates the matching write-back addresses and enables for `oY_0`/`oY_1`. It initiates every butterfly of every stage, delays addresses to match the RAM and butterfly pipeline, and reports completion to the top-level controller. It performs no arithmetic on data.

## Interface
- `LOG_N`, 4: transform size N = 2^LOG_N; legal range 2..12.
- `PIPE_LAT`, 3: cycles from a butterfly's x1/x2 address issue to its write-back (1 RAM read + 2 butterfly).
- `X0_SKEW`, 1: cycles by which `oADDR_X0` lags `oADDR_X1`/`oADDR_X2` for the same butterfly; must be < PIPE_LAT.
- `iCLK` in 1: clock, rising edge.
- `iRESET` in 1: asynchronous, active-high reset.
- `iSTART` in 1: start pulse, sampled only in IDLE.
- `oBUSY` out 1: high in RUN and DRAIN.
- `oDONE` out 1: one-cycle pulse at end of transform.
- `oRD_EN` out 1: x1/x2/twiddle read strobe.
- `oADDR_X1`, `oADDR_X2` out LOG_N: odd-half operand addresses.
- `oRD_EN_X0` out 1: `oRD_EN` delayed X0_SKEW.
- `oADDR_X0` out LOG_N: even-half operand address, delayed X0_SKEW.
- `oADDR_TW` out LOG_N-1: twiddle ROM index j (angle 2πj/N).
- `oRD_BANK` out 1: bank being read; write bank is its inverse.
- `oWR_EN` out 1: write strobe for y0/y1.
- `oADDR_Y0`, `oADDR_Y1` out LOG_N: write-back addresses.

## Operation
- Bank 0 holds bit-reversed input before `iSTART`; loading it is the caller's job. The result lands in bank (LOG_N mod 2).
- FSM: IDLE -> RUN on `iSTART`; RUN -> DRAIN after the last of N/2 butterflies in the stage; DRAIN -> RUN (next stage) after PIPE_LAT cycles; DRAIN -> DONE if the stage was LOG_N-1; DONE -> IDLE unconditionally.
- Per stage s: H = 2^s, B = 2H. Butterfly counter c = 0..N/2-1, one per RUN cycle, g = c >> s, k = c & (H-1).
  - idx0 = g·B + k; idx1 = idx0 + H; idx2 = g·B + H + ((H-k) mod H). k = 0 gives idx2 = idx1.
  - `oADDR_TW` = k << (LOG_N-1-s).
- Write-back: `oADDR_Y0` = idx0 and `oADDR_Y1` = idx1, with `oWR_EN`, all delayed PIPE_LAT from issue. `oRD_BANK` = s[0], and it toggles on the DRAIN->RUN transition.
- DRAIN exists because stage s+1 reads the bank stage s writes. No read is issued in DRAIN.
- `iSTART` is ignored outside IDLE. A start in the DONE cycle is also ignored.
- Reset, including mid-transform: all registers and delay lines clear, FSM goes to IDLE, in-flight writes are dropped (`oWR_EN` = 0), and bank contents are undefined.

## Timing
- Reset values: all outputs 0.
- Cycle numbering: `iSTART` is sampled at edge 0.
- Per stage, RUN lasts N/2 cycles and DRAIN lasts PIPE_LAT cycles, so the stage period is N/2 + PIPE_LAT.
- Stage s reads in cycles s·(N/2+PIPE_LAT) + 1 .. + N/2.
- Writes for stage s appear in cycles s·(N/2+PIPE_LAT) + 1 + PIPE_LAT .. + N/2 + PIPE_LAT.
- `oDONE` is high in cycle LOG_N·(N/2+PIPE_LAT) + 1, with `oBUSY` low in that cycle. For N = 16 and defaults this is cycle 45.
- `oRD_EN_X0` is high exactly X0_SKEW cycles after each `oRD_EN`.
- All outputs are registered; there is no combinational path from inputs.

## Structure
- `fht_pkg` holds the FSM state enum, the `clog2`-based width constants, and an address-compute function shared with the bench model.
- Sub-module `fht_dly` is a parameterised-depth, parameterised-width shift register with async clear. It is instantiated for the X0 skew and for the write-back path (enable + two addresses).
- The core is the FSM, the stage/counter registers, and the index arithmetic (shifts and masks only, no multipliers).

## Test plan
- N = 16, defaults, stage 0, c = 5 -> idx0 = 10, idx1 = 11, idx2 = 11, tw = 0.
- Stage 2, c = 5 -> idx0 = 9, idx1 = 13, idx2 = 15, tw = 2. Stage 3, c = 3 -> idx0 = 3, idx1 = 11, idx2 = 13, tw = 3.
- Full run -> exactly 32 `oRD_EN` and 32 `oWR_EN` pulses. `oDONE` in cycle 45. `oRD_BANK` sequence 0,1,0,1. No write to a bank while it is being read.
- `oWR_EN` with `oADDR_Y0`/`oADDR_Y1` trails each read by exactly 3 cycles. `oADDR_X0` trails `oADDR_X1` by 1 cycle. Repeat with PIPE_LAT = 5 -> `oDONE` in cycle 53.
- `iSTART` pulsed during RUN and in the DONE cycle -> ignored; a second start in IDLE runs a clean second transform.
- `iRESET` asserted asynchronously mid stage 1 -> all outputs 0 immediately, FSM in IDLE, no trailing `oWR_EN`. A subsequent `iSTART` gives an identical full run.
- Bench integrates with `fht_but`, RAM and ROM models and compares the 16-point DHT of a random signal against a real-valued reference, with error < 1 LSB·LOG_N.
